// File: rtl/vga_pkg.sv
// Shared 1024x768@60 timing constants, field widths and colour-bar palette for
// the vga_timing slice. Test pattern is compiled in with VGA_TIMING_TEST_PATTERN_EN.
package vga_pkg;

  localparam int HOR_VISIBLE    = 1024;
  localparam int HOR_SYNC_START = 1048;
  localparam int HOR_SYNC_END   = 1183;
  localparam int HOR_TOTAL      = 1344;
  localparam int VER_VISIBLE    = 768;
  localparam int VER_SYNC_START = 771;
  localparam int VER_SYNC_END   = 776;
  localparam int VER_TOTAL      = 806;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 11;

  typedef logic [11:0] rgb12_t;

  // 4:4:4 bar colours, left to right
  localparam rgb12_t RGB_WHITE   = 12'hFFF;
  localparam rgb12_t RGB_YELLOW  = 12'hFF0;
  localparam rgb12_t RGB_CYAN    = 12'h0FF;
  localparam rgb12_t RGB_GREEN   = 12'h0F0;
  localparam rgb12_t RGB_MAGENTA = 12'hF0F;
  localparam rgb12_t RGB_RED     = 12'hF00;
  localparam rgb12_t RGB_BLUE    = 12'h00F;
  localparam rgb12_t RGB_BLACK   = 12'h000;

endpackage

// File: rtl/vga_if.sv
// vga_if bundle: counts, sync/blank flags and colour for one pixel, always
// registered together by the transmitter so receivers see a coherent set.
interface vga_if;
  import vga_pkg::*;

  logic [HCOUNT_W-1:0] hcount;
  logic [VCOUNT_W-1:0] vcount;
  logic                hsync;
  logic                vsync;
  logic                hblnk;
  logic                vblnk;
  rgb12_t              rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_test_pattern.sv
// Combinational eight-bar colour pattern; black whenever the pixel is blanked.
// Only instantiated when VGA_TIMING_TEST_PATTERN_EN is defined.
module vga_test_pattern
  import vga_pkg::*;
#(
  parameter int BAR_W = HOR_VISIBLE / 8
) (
  input  logic [HCOUNT_W-1:0] i_hcount,
  input  logic                i_hblnk,
  input  logic                i_vblnk,
  output rgb12_t              o_rgb
);

  localparam logic [HCOUNT_W-1:0] BAR_W_C = HCOUNT_W'(BAR_W);

  logic [HCOUNT_W-1:0] w_idx;

  assign w_idx = i_hcount / BAR_W_C;

  always_comb begin
    o_rgb = RGB_BLACK;
    if (!i_hblnk && !i_vblnk) begin
      case (w_idx)
        11'd0:   o_rgb = RGB_WHITE;
        11'd1:   o_rgb = RGB_YELLOW;
        11'd2:   o_rgb = RGB_CYAN;
        11'd3:   o_rgb = RGB_GREEN;
        11'd4:   o_rgb = RGB_MAGENTA;
        11'd5:   o_rgb = RGB_RED;
        11'd6:   o_rgb = RGB_BLUE;
        default: o_rgb = RGB_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator driving the vga_if bundle plus a frame_start strobe.
// Define VGA_TIMING_TEST_PATTERN_EN to drive colour bars on rgb instead of 0.
module vga_timing #(
  parameter int HOR_VISIBLE    = vga_pkg::HOR_VISIBLE,
  parameter int HOR_SYNC_START = vga_pkg::HOR_SYNC_START,
  parameter int HOR_SYNC_END   = vga_pkg::HOR_SYNC_END,
  parameter int HOR_TOTAL      = vga_pkg::HOR_TOTAL,
  parameter int VER_VISIBLE    = vga_pkg::VER_VISIBLE,
  parameter int VER_SYNC_START = vga_pkg::VER_SYNC_START,
  parameter int VER_SYNC_END   = vga_pkg::VER_SYNC_END,
  parameter int VER_TOTAL      = vga_pkg::VER_TOTAL
) (
  input  logic clk65MHz,
  input  logic rst,
  vga_if.out   vga_out,
  output logic frame_start
);
  import vga_pkg::*;

  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(HOR_TOTAL - 1);
  localparam logic [HCOUNT_W-1:0] H_VIS  = HCOUNT_W'(HOR_VISIBLE);
  localparam logic [HCOUNT_W-1:0] H_SS   = HCOUNT_W'(HOR_SYNC_START);
  localparam logic [HCOUNT_W-1:0] H_SE   = HCOUNT_W'(HOR_SYNC_END);
  localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(VER_TOTAL - 1);
  localparam logic [VCOUNT_W-1:0] V_VIS  = VCOUNT_W'(VER_VISIBLE);
  localparam logic [VCOUNT_W-1:0] V_SS   = VCOUNT_W'(VER_SYNC_START);
  localparam logic [VCOUNT_W-1:0] V_SE   = VCOUNT_W'(VER_SYNC_END);

  logic [HCOUNT_W-1:0] r_hcount, w_h_next;
  logic [VCOUNT_W-1:0] r_vcount, w_v_next;
  logic                r_hsync, r_vsync, r_hblnk, r_vblnk, r_frame_start;
  rgb12_t              r_rgb, w_rgb_next;
  logic                w_h_wrap;
  logic                w_hsync_next, w_vsync_next, w_hblnk_next, w_vblnk_next;
  logic                w_frame_start_next;

  always_comb begin
    w_h_wrap = (r_hcount == H_LAST);
    w_h_next = w_h_wrap ? '0 : r_hcount + 1'b1;
    w_v_next = r_vcount;
    if (w_h_wrap) begin
      w_v_next = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
    end
  end

  // Flags come from the next counts so every field registers for the same pixel.
  assign w_hblnk_next = (w_h_next >= H_VIS);
  assign w_hsync_next = (w_h_next >= H_SS) && (w_h_next <= H_SE);
  assign w_vblnk_next = (w_v_next >= V_VIS);
  assign w_vsync_next = (w_v_next >= V_SS) && (w_v_next <= V_SE);

  // Counting only ever reaches 0,0 by wrapping, so the reset-exit cycle never pulses.
  assign w_frame_start_next = (w_h_next == '0) && (w_v_next == '0);

`ifdef VGA_TIMING_TEST_PATTERN_EN
  vga_test_pattern #(
    .BAR_W(HOR_VISIBLE / 8)
  ) u_pattern (
    .i_hcount(w_h_next),
    .i_hblnk (w_hblnk_next),
    .i_vblnk (w_vblnk_next),
    .o_rgb   (w_rgb_next)
  );
`else
  assign w_rgb_next = '0;
`endif

  always_ff @(posedge clk65MHz) begin
    if (!rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_hsync       <= w_hsync_next;
      r_vsync       <= w_vsync_next;
      r_hblnk       <= w_hblnk_next;
      r_vblnk       <= w_vblnk_next;
      r_rgb         <= w_rgb_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  assign vga_out.hcount = r_hcount;
  assign vga_out.vcount = r_vcount;
  assign vga_out.hsync  = r_hsync;
  assign vga_out.vsync  = r_vsync;
  assign vga_out.hblnk  = r_hblnk;
  assign vga_out.vblnk  = r_vblnk;
  assign vga_out.rgb    = r_rgb;
  assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance for line-level checks and a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_timing;

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
    logic [11:0] rgb;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic fs_a, fs_b;

  int total = 0;
  int bad = 0;

  longint t_a = 0, t_b = 0;
  bit live_a = 1'b0, live_b = 1'b0;
  int cur_a = 0, cur_b = 0;
  bit done_a = 1'b0, done_b = 1'b0;

  vga_if if_a ();
  vga_if if_b ();

  // clock / reset block
  always #5 clk = ~clk;

  vga_timing dut_a (
    .clk65MHz   (clk),
    .rst        (rst_a),
    .vga_out    (if_a),
    .frame_start(fs_a)
  );

  vga_timing #(
    .HOR_VISIBLE   (16),
    .HOR_SYNC_START(18),
    .HOR_SYNC_END  (21),
    .HOR_TOTAL     (24),
    .VER_VISIBLE   (10),
    .VER_SYNC_START(11),
    .VER_SYNC_END  (12),
    .VER_TOTAL     (14)
  ) dut_b (
    .clk65MHz   (clk),
    .rst        (rst_b),
    .vga_out    (if_b),
    .frame_start(fs_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: t = cycles of counting since the last reset edge.
  function automatic obs_t model(input longint t, input int hv, input int hss, input int hse,
                                 input int ht, input int vv, input int vss, input int vse,
                                 input int vt);
    obs_t m;
    int hc, vc;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif
    hc = int'(t % ht);
    vc = int'((t / ht) % vt);
    m.hc = 11'(hc);
    m.vc = 11'(vc);
    m.hb = (hc >= hv);
    m.hs = (hc >= hss) && (hc <= hse);
    m.vb = (vc >= vv);
    m.vs = (vc >= vss) && (vc <= vse);
    m.fs = (t != 0) && ((t % (longint'(ht) * vt)) == 0);
    m.rgb = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    if (t != 0 && !m.hb && !m.vb) m.rgb = bars[hc / (hv / 8)];
`endif
    return m;
  endfunction

  task automatic cmp(input string nm, input obs_t a, input obs_t e);
    chk({nm, "_hcount"}, 32'(a.hc), 32'(e.hc));
    chk({nm, "_vcount"}, 32'(a.vc), 32'(e.vc));
    chk({nm, "_hsync"}, 32'(a.hs), 32'(e.hs));
    chk({nm, "_vsync"}, 32'(a.vs), 32'(e.vs));
    chk({nm, "_hblnk"}, 32'(a.hb), 32'(e.hb));
    chk({nm, "_vblnk"}, 32'(a.vb), 32'(e.vb));
    chk({nm, "_frame_start"}, 32'(a.fs), 32'(e.fs));
    chk({nm, "_rgb"}, 32'(a.rgb), 32'(e.rgb));
  endtask

  always @(posedge clk) begin
    if (!rst_a) begin
      t_a <= 0;
      live_a <= 1'b1;
    end else if (live_a) t_a <= t_a + 1;
    if (!rst_b) begin
      t_b <= 0;
      live_b <= 1'b1;
    end else if (live_b) t_b <= t_b + 1;
  end

  // scoreboard: every cycle, both instances against the model
  always @(negedge clk) begin
    obs_t oa, ob;
    if (live_a) begin
      oa.hc = if_a.hcount; oa.vc = if_a.vcount; oa.hs = if_a.hsync; oa.vs = if_a.vsync;
      oa.hb = if_a.hblnk; oa.vb = if_a.vblnk; oa.fs = fs_a; oa.rgb = if_a.rgb;
      cmp("mdl_a", oa, model(t_a, 1024, 1048, 1183, 1344, 768, 771, 776, 806));
    end
    if (live_b) begin
      ob.hc = if_b.hcount; ob.vc = if_b.vcount; ob.hs = if_b.hsync; ob.vs = if_b.vsync;
      ob.hb = if_b.hblnk; ob.vb = if_b.vblnk; ob.fs = fs_b; ob.rgb = if_b.rgb;
      cmp("mdl_b", ob, model(t_b, 16, 18, 21, 24, 10, 11, 12, 14));
    end
  end

  // driver tasks
  task automatic goto_a(input int target);
    while (cur_a < target) begin
      @(negedge clk);
      cur_a++;
    end
  endtask

  task automatic goto_b(input int target);
    while (cur_b < target) begin
      @(negedge clk);
      cur_b++;
    end
  endtask

  // full-size instance: line timing, pattern, mid-frame reset
  initial begin
    int hs_n;
    logic [11:0] e_fff, e_ff0, e_f00, e_00f;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    e_fff = 12'hFFF; e_ff0 = 12'hFF0; e_f00 = 12'hF00; e_00f = 12'h00F;
`else
    e_fff = 12'h000; e_ff0 = 12'h000; e_f00 = 12'h000; e_00f = 12'h000;
`endif
    rst_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("a_rst_hcount", 32'(if_a.hcount), 0);
    chk("a_rst_hblnk", 32'(if_a.hblnk), 0);
    chk("a_rst_rgb", 32'(if_a.rgb), 0);
    rst_a = 1'b1;
    cur_a = 0;
    chk("a_rel_fs", 32'(fs_a), 0);
    goto_a(1);    chk("a_hc1", 32'(if_a.hcount), 1);
    goto_a(2);    chk("a_hc2", 32'(if_a.hcount), 2);
    chk("a_vc_line0", 32'(if_a.vcount), 0);
    goto_a(1023); chk("a_hblnk_1023", 32'(if_a.hblnk), 0);
    hs_n = 0;
    for (int t = 1024; t <= 1343; t++) begin
      goto_a(t);
      if (t == 1024) chk("a_hblnk_1024", 32'(if_a.hblnk), 1);
      if (t == 1047) chk("a_hsync_1047", 32'(if_a.hsync), 0);
      if (t == 1048) chk("a_hsync_1048", 32'(if_a.hsync), 1);
      if (t == 1184) chk("a_hsync_1184", 32'(if_a.hsync), 0);
      if (if_a.hsync) hs_n++;
    end
    chk("a_hsync_len", 32'(hs_n), 136);
    chk("a_hc_last", 32'(if_a.hcount), 1343);
    goto_a(1344);
    chk("a_wrap_hc", 32'(if_a.hcount), 0);
    chk("a_wrap_vc", 32'(if_a.vcount), 1);
    chk("a_wrap_fs", 32'(fs_a), 0);
    goto_a(13440);        chk("a_rgb_l10_0", 32'(if_a.rgb), 32'(e_fff));
    goto_a(13440 + 128);  chk("a_rgb_l10_128", 32'(if_a.rgb), 32'(e_ff0));
    goto_a(13440 + 767);  chk("a_rgb_l10_767", 32'(if_a.rgb), 32'(e_f00));
    goto_a(13440 + 768);  chk("a_rgb_l10_768", 32'(if_a.rgb), 32'(e_00f));
    goto_a(13440 + 1023); chk("a_rgb_l10_1023", 32'(if_a.rgb), 0);
    goto_a(13440 + 1024); chk("a_rgb_l10_1024", 32'(if_a.rgb), 0);
    goto_a(13440 + 1100);
    chk("a_pre_rst_vc", 32'(if_a.vcount), 10);
    chk("a_pre_rst_hs", 32'(if_a.hsync), 1);
    rst_a = 1'b0;
    @(negedge clk);
    chk("a_mid_rst_hc", 32'(if_a.hcount), 0);
    chk("a_mid_rst_vc", 32'(if_a.vcount), 0);
    chk("a_mid_rst_hs", 32'(if_a.hsync), 0);
    chk("a_mid_rst_hb", 32'(if_a.hblnk), 0);
    rst_a = 1'b1;
    cur_a = 0;
    goto_a(3);    chk("a_resume_hc3", 32'(if_a.hcount), 3);
    goto_a(2000);
    done_a = 1'b1;
  end

  // shrunken instance: frame period, vertical flags, mid-frame reset
  initial begin
    int nfs, p1, p2, vs_n, vb_n;
    nfs = 0; p1 = 0; p2 = 0; vs_n = 0; vb_n = 0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    cur_b = 0;
    for (int t = 1; t <= 700; t++) begin
      goto_b(t);
      if (fs_b) begin
        nfs++;
        if (nfs == 1) p1 = t;
        else p2 = t;
      end
      if (t >= 336 && t < 672) begin
        if (if_b.vsync) vs_n++;
        if (if_b.vblnk) vb_n++;
      end
    end
    chk("b_fs_count", 32'(nfs), 2);
    chk("b_fs_first", 32'(p1), 336);
    chk("b_fs_period", 32'(p2 - p1), 336);
    chk("b_vsync_cycles", 32'(vs_n), 48);
    chk("b_vblnk_cycles", 32'(vb_n), 96);
    goto_b(672 + 284);
    chk("b_pre_rst_vs", 32'(if_b.vsync), 1);
    chk("b_pre_rst_vb", 32'(if_b.vblnk), 1);
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_mid_rst_vc", 32'(if_b.vcount), 0);
    chk("b_mid_rst_vs", 32'(if_b.vsync), 0);
    chk("b_mid_rst_vb", 32'(if_b.vblnk), 0);
    rst_b = 1'b1;
    cur_b = 0;
    goto_b(400);
    done_b = 1'b1;
  end

  // final report
  initial begin
    wait (done_a && done_b);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog run did not complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
